// File: rtl/sprite_draw_scheduler_pkg.sv
// Shared types and constants for the sprite draw scheduler: FSM state encoding,
// VGA field widths and the default frame divider.
package sprite_draw_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ER_REQ  = 3'd1,
        ER_WAIT = 3'd2,
        MOVE    = 3'd3,
        DR_REQ  = 3'd4,
        DR_WAIT = 3'd5
    } state_e;

    localparam int X_W   = 9;
    localparam int Y_W   = 8;
    localparam int COL_W = 3;

    // 50 MHz system clock divided down to a 60 Hz frame tick
    localparam int FRAME_CYCLES_DEF = 833334;

endpackage

// File: rtl/sprite_draw_scheduler_frame_tick_gen.sv
// Frame divider: counts 0..DIV-1 and raises tick_o for one cycle on the wrap count.
module sprite_draw_scheduler_frame_tick_gen
    import sprite_draw_scheduler_pkg::*;
#(
    parameter int DIV = FRAME_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic reset_i,
    output logic tick_o
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick_o = (cnt_q == CNT_LAST);
        cnt_d  = tick_o ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sprite_draw_scheduler.sv
// Per-frame erase / move / redraw sequencer for the sprite engines, with a registered
// pixel mux onto the VGA write port. Build with SPRITE_SCHED_WATCHDOG_EN for the done watchdog.
module sprite_draw_scheduler
    import sprite_draw_scheduler_pkg::*;
#(
    parameter int NUM_SPR      = 4,
    parameter int FRAME_CYCLES = FRAME_CYCLES_DEF,
    parameter int WAIT_LIMIT   = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [NUM_SPR-1:0]       draw_req,
    output logic [NUM_SPR-1:0]       erase_req,
    output logic                     move_tick,
    input  logic [NUM_SPR-1:0]       spr_done,
    input  logic [NUM_SPR-1:0]       spr_valid,
    input  logic [X_W*NUM_SPR-1:0]   spr_x,
    input  logic [Y_W*NUM_SPR-1:0]   spr_y,
    input  logic [COL_W*NUM_SPR-1:0] spr_colour,
    output logic [X_W-1:0]           x,
    output logic [Y_W-1:0]           y,
    output logic [COL_W-1:0]         colour,
    output logic                     plot,
    output logic                     frame_busy,
    output logic                     overrun,
    output logic [NUM_SPR-1:0]       hang_err
);

    localparam int IDX_W = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPR - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             frame_tick;
    logic             in_wait;
    logic             done_hit;
    logic             advance;
    logic             overrun_q;
    logic             plot_q;
    logic [X_W-1:0]   x_q;
    logic [Y_W-1:0]   y_q;
    logic [COL_W-1:0] col_q;

    logic [X_W-1:0]   spr_x_a   [NUM_SPR];
    logic [Y_W-1:0]   spr_y_a   [NUM_SPR];
    logic [COL_W-1:0] spr_col_a [NUM_SPR];

    for (genvar g = 0; g < NUM_SPR; g++) begin : g_unpack
        assign spr_x_a[g]   = spr_x[g*X_W +: X_W];
        assign spr_y_a[g]   = spr_y[g*Y_W +: Y_W];
        assign spr_col_a[g] = spr_colour[g*COL_W +: COL_W];
    end

    sprite_draw_scheduler_frame_tick_gen #(
        .DIV(FRAME_CYCLES)
    ) u_tick (
        .clk_i  (clk),
        .reset_i(reset),
        .tick_o (frame_tick)
    );

    // Only the active sprite's done counts, and only once its req strobe is over
    assign in_wait  = (state_q == ER_WAIT) || (state_q == DR_WAIT);
    assign done_hit = in_wait && spr_done[idx_q];

`ifdef SPRITE_SCHED_WATCHDOG_EN
    localparam int WD_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WAIT_LIMIT - 1);

    logic [WD_W-1:0]    wd_q, wd_d;
    logic [NUM_SPR-1:0] hang_q, hang_d;
    logic               timeout;

    assign timeout = in_wait && !done_hit && (wd_q == WD_LAST);
    assign advance = done_hit || timeout;

    always_comb begin
        wd_d   = wd_q;
        hang_d = hang_q;
        if (state_d != state_q) begin
            wd_d = '0;
        end else if (in_wait) begin
            wd_d = wd_q + 1'b1;
        end
        if (timeout) begin
            hang_d[idx_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q   <= '0;
            hang_q <= '0;
        end else begin
            wd_q   <= wd_d;
            hang_q <= hang_d;
        end
    end

    assign hang_err = hang_q;
`else
    assign advance  = done_hit;
    // WAIT_LIMIT has no effect without the watchdog; the flags stay low
    assign hang_err = {NUM_SPR{1'b0}} & {NUM_SPR{WAIT_LIMIT > 0}};
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        erase_req = '0;
        draw_req  = '0;
        move_tick = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    idx_d   = '0;
                    state_d = ER_REQ;
                end
            end
            ER_REQ: begin
                erase_req[idx_q] = 1'b1;
                state_d          = ER_WAIT;
            end
            ER_WAIT: begin
                if (advance) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = MOVE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ER_REQ;
                    end
                end
            end
            MOVE: begin
                move_tick = 1'b1;
                idx_d     = '0;
                state_d   = DR_REQ;
            end
            DR_REQ: begin
                draw_req[idx_q] = 1'b1;
                state_d         = DR_WAIT;
            end
            DR_WAIT: begin
                if (advance) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = DR_REQ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Pixel fields load from the active sprite while waiting and hold otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            plot_q <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
            col_q  <= '0;
        end else if (in_wait) begin
            plot_q <= spr_valid[idx_q];
            x_q    <= spr_x_a[idx_q];
            y_q    <= spr_y_a[idx_q];
            col_q  <= spr_col_a[idx_q];
        end else begin
            plot_q <= 1'b0;
        end
    end

    // A tick during a frame is dropped; only the sticky flag records it
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_q <= 1'b0;
        end else if (frame_tick && (state_q != IDLE)) begin
            overrun_q <= 1'b1;
        end
    end

    assign frame_busy = (state_q != IDLE);
    assign overrun    = overrun_q;
    assign plot       = plot_q;
    assign x          = x_q;
    assign y          = y_q;
    assign colour     = col_q;

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Scoreboard bench for sprite_draw_scheduler (NUM_SPR=2, FRAME_CYCLES=20, WAIT_LIMIT=8);
// expectations follow SPRITE_SCHED_WATCHDOG_EN when it is defined.
module tb_sprite_draw_scheduler;

    localparam int NS = 2;
    localparam int FC = 20;
    localparam int WL = 8;
`ifdef SPRITE_SCHED_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    typedef struct packed {
        logic [1:0] er;
        logic [1:0] dr;
        logic       mv;
        logic       pl;
        logic [8:0] px;
        logic [7:0] py;
        logic [2:0] pc;
    } ev_t;

    logic          clk;
    logic          reset;
    logic [NS-1:0] draw_req, erase_req, hang_err;
    logic          move_tick, plot, frame_busy, overrun;
    logic [NS-1:0] spr_done, spr_valid, resp_done, stray_done;
    logic [9*NS-1:0] spr_x;
    logic [8*NS-1:0] spr_y;
    logic [3*NS-1:0] spr_colour;
    logic [8:0]    x;
    logic [7:0]    y;
    logic [2:0]    colour;

    ev_t exp_q[$];
    int  n_vec = 0;
    int  n_err = 0;
    int  cyc   = 0;
    int  lat_s [NS];

    assign spr_done = resp_done | stray_done;

    sprite_draw_scheduler #(
        .NUM_SPR     (NS),
        .FRAME_CYCLES(FC),
        .WAIT_LIMIT  (WL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .draw_req  (draw_req),
        .erase_req (erase_req),
        .move_tick (move_tick),
        .spr_done  (spr_done),
        .spr_valid (spr_valid),
        .spr_x     (spr_x),
        .spr_y     (spr_y),
        .spr_colour(spr_colour),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .plot      (plot),
        .frame_busy(frame_busy),
        .overrun   (overrun),
        .hang_err  (hang_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mk(input logic [1:0] er, input logic [1:0] dr, input logic mv,
                               input logic pl, input logic [8:0] px, input logic [7:0] py,
                               input logic [2:0] pc);
        ev_t e;
        e.er = er; e.dr = dr; e.mv = mv; e.pl = pl;
        e.px = pl ? px : 9'd0;
        e.py = pl ? py : 8'd0;
        e.pc = pl ? pc : 3'd0;
        return e;
    endfunction

    task automatic push_frame();
        exp_q.push_back(mk(2'b01, 2'b00, 1'b0, 1'b0, 9'd0, 8'd0, 3'd0));
        exp_q.push_back(mk(2'b10, 2'b00, 1'b0, 1'b0, 9'd0, 8'd0, 3'd0));
        exp_q.push_back(mk(2'b00, 2'b00, 1'b1, 1'b0, 9'd0, 8'd0, 3'd0));
        exp_q.push_back(mk(2'b00, 2'b01, 1'b0, 1'b0, 9'd0, 8'd0, 3'd0));
        exp_q.push_back(mk(2'b00, 2'b10, 1'b0, 1'b0, 9'd0, 8'd0, 3'd0));
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    task automatic wait_req(input bit is_draw, input logic w, output int t);
        logic [NS-1:0] v;
        bit hit;
        hit = 1'b0;
        t   = -1;
        for (int n = 0; n < 60 && !hit; n++) begin
            @(negedge clk);
            v = is_draw ? draw_req : erase_req;
            if (v[w] === 1'b1) begin
                hit = 1'b1;
                t   = cyc;
            end
        end
        if (!hit) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_%s%0d: strobe absent after 60 cycles", is_draw ? "draw" : "erase", w);
        end
    endtask

    task automatic wait_idle();
        bit hit;
        hit = 1'b0;
        for (int n = 0; n < 60 && !hit; n++) begin
            @(negedge clk);
            if (frame_busy === 1'b0) hit = 1'b1;
        end
        if (!hit) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_idle: frame_busy still high after 60 cycles");
        end
    endtask

    // Sprite responders: done pulses lat_s[i] cycles after the sprite's req strobe
    initial begin
        int cnt [NS];
        resp_done = '0;
        for (int i = 0; i < NS; i++) cnt[i] = 0;
        forever begin
            @(negedge clk);
            resp_done = '0;
            for (int i = 0; i < NS; i++) begin
                if (cnt[i] > 0) begin
                    cnt[i]--;
                    if (cnt[i] == 0) resp_done[i] = 1'b1;
                end
                if (erase_req[i] === 1'b1 || draw_req[i] === 1'b1) cnt[i] = lat_s[i];
            end
        end
    end

    // Monitor: every cycle with a strobe or a plot must match the next queued event
    initial begin
        ev_t obs;
        ev_t e;
        forever begin
            @(negedge clk);
            if ((|{erase_req, draw_req, move_tick, plot}) === 1'b1) begin
                obs = mk(erase_req, draw_req, move_tick, plot, x, y, colour);
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL event: unexpected er=%b dr=%b mv=%b pl=%b at cycle %0d",
                             obs.er, obs.dr, obs.mv, obs.pl, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (obs !== e) begin
                        n_err++;
                        $display("FAIL event@%0d: got er=%b dr=%b mv=%b pl=%b x=%0d y=%0d c=%b, expected er=%b dr=%b mv=%b pl=%b x=%0d y=%0d c=%b",
                                 cyc, obs.er, obs.dr, obs.mv, obs.pl, obs.px, obs.py, obs.pc,
                                 e.er, e.dr, e.mv, e.pl, e.px, e.py, e.pc);
                    end
                end
            end
        end
    end

    initial begin
        int rel, rel2, t0, t1, td, tp;
        reset      = 1'b1;
        spr_valid  = '0;
        spr_x      = '0;
        spr_y      = '0;
        spr_colour = '0;
        stray_done = '0;
        lat_s[0]   = 3;
        lat_s[1]   = 3;
        repeat (3) @(negedge clk);
        check("reset_state", {erase_req, draw_req, move_tick, plot, x, y, colour,
                              frame_busy, overrun, hang_err}, 32'd0);
        reset = 1'b0;
        rel   = cyc;

        // Frame 1: order, stray dones, pixel forwarding, frame_busy fall
        exp_q.push_back(mk(2'b01, 2'b00, 1'b0, 1'b0, 9'd0, 8'd0, 3'd0));
        exp_q.push_back(mk(2'b10, 2'b00, 1'b0, 1'b0, 9'd0, 8'd0, 3'd0));
        exp_q.push_back(mk(2'b00, 2'b00, 1'b0, 1'b1, 9'd150, 8'd100, 3'b001));
        exp_q.push_back(mk(2'b00, 2'b00, 1'b1, 1'b1, 9'd151, 8'd101, 3'b110));
        exp_q.push_back(mk(2'b00, 2'b01, 1'b0, 1'b0, 9'd0, 8'd0, 3'd0));
        exp_q.push_back(mk(2'b00, 2'b10, 1'b0, 1'b0, 9'd0, 8'd0, 3'd0));
        wait_req(1'b0, 1'b0, t0);
        check("f1_start", t0, rel + FC);
        stray_done = 2'b01;
        @(negedge clk);
        stray_done = 2'b10;
        @(negedge clk);
        stray_done = 2'b00;
        wait_req(1'b0, 1'b1, t1);
        check("f1_er1_gap", t1 - t0, 4);
        @(negedge clk);
        spr_valid  = 2'b11;
        spr_x      = {9'd150, 9'd7};
        spr_y      = {8'd100, 8'd7};
        spr_colour = {3'b001, 3'b111};
        @(negedge clk);
        spr_valid  = 2'b01;
        @(negedge clk);
        spr_valid  = 2'b10;
        spr_x      = {9'd151, 9'd7};
        spr_y      = {8'd101, 8'd7};
        spr_colour = {3'b110, 3'b111};
        @(negedge clk);
        spr_valid  = 2'b00;
        wait_req(1'b1, 1'b1, td);
        repeat (3) @(negedge clk);
        check("f1_busy_at_done", frame_busy, 1);
        @(negedge clk);
        check("f1_busy_after", frame_busy, 0);
        stray_done = 2'b01;
        @(negedge clk);
        stray_done = 2'b00;
        check("idle_stray_busy", frame_busy, 0);
        tp = t0;

        // Frame 2: plain frame one tick later
        push_frame();
        wait_req(1'b0, 1'b0, t0);
        check("f2_start", t0, tp + FC);
        tp = t0;
        wait_req(1'b1, 1'b1, td);
        wait_idle();
        check("f2_no_overrun", overrun, 0);
        lat_s[0] = 5;
        lat_s[1] = 5;

        // Frame 3: 25-cycle frame overruns the 20-cycle tick
        push_frame();
        wait_req(1'b0, 1'b0, t0);
        check("f3_start", t0, tp + FC);
        tp = t0;
        wait_req(1'b1, 1'b1, td);
        wait_idle();
        check("f3_overrun", overrun, 1);
        lat_s[0] = 3;
        lat_s[1] = 3;

        // Frame 4: dropped tick delays the start; reset abandons it in DR_WAIT
        exp_q.push_back(mk(2'b01, 2'b00, 1'b0, 1'b0, 9'd0, 8'd0, 3'd0));
        exp_q.push_back(mk(2'b10, 2'b00, 1'b0, 1'b0, 9'd0, 8'd0, 3'd0));
        exp_q.push_back(mk(2'b00, 2'b00, 1'b1, 1'b0, 9'd0, 8'd0, 3'd0));
        exp_q.push_back(mk(2'b00, 2'b01, 1'b0, 1'b0, 9'd0, 8'd0, 3'd0));
        exp_q.push_back(mk(2'b00, 2'b00, 1'b0, 1'b1, 9'd300, 8'd200, 3'b101));
        wait_req(1'b0, 1'b0, t0);
        check("f4_start", t0, tp + 2 * FC);
        wait_req(1'b1, 1'b0, td);
        @(negedge clk);
        spr_valid  = 2'b01;
        spr_x      = {9'd0, 9'd300};
        spr_y      = {8'd0, 8'd200};
        spr_colour = {3'b000, 3'b101};
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midframe_reset", {plot, frame_busy, erase_req, draw_req, move_tick, overrun}, 32'd0);
        reset     = 1'b0;
        spr_valid = 2'b00;
        rel2      = cyc;
        lat_s[0]  = 10;

        // Frame 5: sprite 0 answers after 10 cycles, past the watchdog limit
        push_frame();
        wait_req(1'b0, 1'b0, t0);
        check("f5_start", t0, rel2 + FC);
        wait_req(1'b0, 1'b1, t1);
        check("f5_er1_gap", t1 - t0, WD ? (WL + 1) : 11);
        wait_req(1'b1, 1'b1, td);
        check("f5_hang_err", hang_err, WD ? 2 'b01 : 2'b00);
        wait_idle();
        repeat (2) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
